inst_axi_rd_bridge: RTL and testbench

//  Converts the instruction-fetch SRAM-like interface (req/addr_ok/data_ok) into an AXI4 read channel (AR/R).

---
 rtl/inst_axi_rd_bridge_if.sv | 40 ++++
 rtl/inst_axi_rd_bridge.sv | 110 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for inst_axi_rd_bridge: the IF-side SRAM-like fetch port and the AXI4 read channel.
interface inst_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [3:0]  axi_arid;

  modport master (output req, wr, size, addr, input addr_ok, data_ok, rdata, axi_arid);
  modport slave  (input req, wr, size, addr, output addr_ok, data_ok, rdata, axi_arid);
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  output rready,
                  input  arready, rid, rresp, rlast, rdata, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  input  rready,
                  output arready, rid, rresp, rlast, rdata, rvalid);
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch SRAM-like to AXI4 read bridge; one AR in flight, up to MAX_OUTS reads outstanding.
// Define INST_BRIDGE_RBUF_EN to register R beats in a 1-entry buffer (data_ok one cycle after rvalid).
module inst_axi_rd_bridge #(
  parameter logic [3:0]  ARID_VAL = 4'd0,
  parameter int unsigned MAX_OUTS = 2
) (
  input logic        clk,
  input logic        reset,
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  logic [0:0]       ar_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      araddr_q;
  logic [1:0]       size_q;
  logic             accept;
  logic             complete;
  logic             rid_match;

  // Writes are never accepted, and a new fetch waits until the previous AR has left.
  assign accept    = (ar_state == AR_IDLE) && sram.req && !sram.wr && (cnt < CNT_MAX);
  assign rid_match = (axi.rid == ARID_VAL);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples its pre-edge inputs.
    if (reset) begin
      ar_state <= AR_IDLE;
      araddr_q <= '0;
      size_q   <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: if (accept) begin
          ar_state <= AR_SEND;
          araddr_q <= sram.addr;
          size_q   <= sram.size;
        end
        AR_SEND: if (axi.arready) ar_state <= AR_IDLE;
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // Outstanding reads: accepted but not yet returned to IF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept && !complete) begin
      cnt <= cnt + CNT_ONE;
    end else if (!accept && complete) begin
      cnt <= cnt - CNT_ONE;
    end
  end

`ifdef INST_BRIDGE_RBUF_EN
  logic        buf_full;
  logic [31:0] buf_data;
  logic        beat_ok;

  // Mismatched-ID and unsolicited beats are consumed but never enter the buffer.
  assign beat_ok = axi.rvalid && rid_match && (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
    end else begin
      buf_full <= !buf_full && beat_ok;
    end
  end

  // NOTE: the payload register carries no reset; buf_full alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (!buf_full && beat_ok) buf_data <= axi.rdata;
  end

  assign axi.rready = !buf_full;
  assign complete   = buf_full;
  assign sram.rdata = buf_data;
`else
  assign axi.rready = 1'b1;
  assign complete   = axi.rvalid && rid_match && (cnt != '0);
  assign sram.rdata = axi.rdata;
`endif

  assign sram.addr_ok  = accept;
  assign sram.data_ok  = complete;
  assign sram.axi_arid = ARID_VAL;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (ar_state == AR_SEND);

  // Error responses still complete the fetch; rlast is implied by single-beat bursts.
  logic unused_r;
  assign unused_r = ^{axi.rresp, axi.rlast};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge: directed fetches, AR/R handshakes, limits and reset.
module tb_inst_axi_rd_bridge;

  logic clk = 1'b0;
  logic reset;

  inst_sram_if s();
  axi_rd_if    a();

  inst_axi_rd_bridge #(.ARID_VAL(4'd0), .MAX_OUTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sram  (s),
    .axi   (a)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_exp_t;

  ar_exp_t     ar_q[$];
  logic [31:0] d_q[$];
  int          total = 0;
  int          bad   = 0;
  ar_exp_t     mon_e;
  logic [31:0] mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every AR handshake and every data_ok is matched against the expectation queues.
  always @(negedge clk) begin
    if (!reset && a.arvalid && a.arready) begin
      if (ar_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got AR addr 0x%0h want no AR", a.araddr);
      end else begin
        mon_e = ar_q.pop_front();
        check("araddr", a.araddr, mon_e.addr);
        check("arsize", {29'd0, a.arsize}, {30'd0, mon_e.size});
        check("ar_fixed", {9'd0, a.arlen, a.arburst, a.arlock, a.arcache, a.arprot, a.arid},
              {9'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0});
      end
    end
    if (!reset && s.data_ok) begin
      if (d_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL data_ok_unexpected: got data_ok rdata 0x%0h want no data_ok", s.rdata);
      end else begin
        mon_d = d_q.pop_front();
        check("rdata", s.rdata, mon_d);
      end
    end
  end

  task automatic req_once(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic exp_ok);
    s.req  = 1'b1;
    s.wr   = 1'b0;
    s.addr = addr;
    s.size = size;
    #1 check(name, {31'd0, s.addr_ok}, {31'd0, exp_ok});
    if (exp_ok) ar_q.push_back({addr, size});
    tick();
    s.req = 1'b0;
  endtask

  task automatic ar_hs(input string name);
    int n = 0;
    while (!a.arvalid && n < 8) begin
      tick();
      n++;
    end
    check(name, {31'd0, a.arvalid}, 32'd1);
    if (a.arvalid) begin
      a.arready = 1'b1;
      tick();
      a.arready = 1'b0;
    end
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic exp);
    a.rvalid = 1'b1;
    a.rid    = 4'd0;
    a.rresp  = resp;
    a.rdata  = data;
    if (exp) d_q.push_back(data);
    tick();
    a.rvalid = 1'b0;
    a.rresp  = 2'b00;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test want end before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    s.req     = 1'b0;
    s.wr      = 1'b0;
    s.size    = 2'd2;
    s.addr    = '0;
    a.arready = 1'b0;
    a.rvalid  = 1'b0;
    a.rid     = 4'd0;
    a.rresp   = 2'b00;
    a.rlast   = 1'b1;
    a.rdata   = '0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_arvalid", {31'd0, a.arvalid}, 32'd0);
    check("rst_addr_ok", {31'd0, s.addr_ok}, 32'd0);
    check("rst_data_ok", {31'd0, s.data_ok}, 32'd0);
    check("rst_rready", {31'd0, a.rready}, 32'd1);
    check("rst_araddr", a.araddr, 32'd0);
    check("rst_arsize", {29'd0, a.arsize}, 32'd0);
    check("rst_axi_arid", {28'd0, s.axi_arid}, 32'd0);
    reset = 1'b0;
    tick();

    // T1: single fetch, cycle-exact.
    s.req  = 1'b1;
    s.addr = 32'h1c00_0000;
    s.size = 2'd2;
    #1 check("t1_addr_ok_c0", {31'd0, s.addr_ok}, 32'd1);
    ar_q.push_back({32'h1c00_0000, 2'd2});
    tick();
    s.req = 1'b0;
    check("t1_arvalid_c1", {31'd0, a.arvalid}, 32'd1);
    check("t1_araddr_c1", a.araddr, 32'h1c00_0000);
    tick();
    a.arready = 1'b1;
    check("t1_arvalid_c2", {31'd0, a.arvalid}, 32'd1);
    tick();
    a.arready = 1'b0;
    check("t1_arvalid_c3", {31'd0, a.arvalid}, 32'd0);
    tick();
    a.rvalid = 1'b1;
    a.rid    = 4'd0;
    a.rdata  = 32'h0280_0413;
    d_q.push_back(32'h0280_0413);
`ifdef INST_BRIDGE_RBUF_EN
    #1 check("t1_data_ok_c4", {31'd0, s.data_ok}, 32'd0);
`else
    #1 check("t1_data_ok_c4", {31'd0, s.data_ok}, 32'd1);
`endif
    tick();
    a.rvalid = 1'b0;
`ifdef INST_BRIDGE_RBUF_EN
    #1 check("t1_data_ok_c5", {31'd0, s.data_ok}, 32'd1);
`else
    #1 check("t1_data_ok_c5", {31'd0, s.data_ok}, 32'd0);
`endif
    tick();

    // T2: arready stalled for 5 cycles; AR held stable, new requests refused.
    req_once("t2_accept", 32'h1c00_0010, 2'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      s.req  = 1'b1;
      s.addr = 32'h1c00_0020;
      #1 check("t2_addr_ok_stall", {31'd0, s.addr_ok}, 32'd0);
      check("t2_arvalid_stall", {31'd0, a.arvalid}, 32'd1);
      check("t2_araddr_stall", a.araddr, 32'h1c00_0010);
      tick();
    end
    s.req = 1'b0;
    ar_hs("t2_ar");
    r_beat(32'h0340_0c0c, 2'b00, 1'b1);

    // T3: outstanding limit of 2; third request waits for a return.
    req_once("t3_accept_a", 32'h1c00_0100, 2'd2, 1'b1);
    ar_hs("t3_ar_a");
    req_once("t3_accept_b", 32'h1c00_0104, 2'd1, 1'b1);
    ar_hs("t3_ar_b");
    s.req  = 1'b1;
    s.addr = 32'h1c00_0108;
    s.size = 2'd2;
    #1 check("t3_full_c", {31'd0, s.addr_ok}, 32'd0);
    tick();
    check("t3_full_c_hold", {31'd0, s.addr_ok}, 32'd0);
    a.rvalid = 1'b1;
    a.rdata  = 32'h1111_0001;
    d_q.push_back(32'h1111_0001);
    #1 check("t3_full_during_ret", {31'd0, s.addr_ok}, 32'd0);
    tick();
    a.rvalid = 1'b0;
    n = 0;
    while (!s.addr_ok && n < 4) begin
      tick();
      n++;
    end
    check("t3_third_accepted", {31'd0, s.addr_ok}, 32'd1);
    ar_q.push_back({32'h1c00_0108, 2'd2});
    tick();
    s.req = 1'b0;
    ar_hs("t3_ar_c");
    r_beat(32'h1111_0002, 2'b00, 1'b1);

    // T4: return of C coincides with acceptance of D at cnt=1; cnt must stay 1.
    s.req    = 1'b1;
    s.addr   = 32'h1c00_0200;
    a.rvalid = 1'b1;
    a.rdata  = 32'h1111_0003;
    d_q.push_back(32'h1111_0003);
    #1 check("t4_addr_ok", {31'd0, s.addr_ok}, 32'd1);
`ifndef INST_BRIDGE_RBUF_EN
    check("t4_data_ok_same", {31'd0, s.data_ok}, 32'd1);
`endif
    ar_q.push_back({32'h1c00_0200, 2'd2});
    tick();
    s.req    = 1'b0;
    a.rvalid = 1'b0;
    tick();
    ar_hs("t4_ar_d");
    req_once("t4_accept_e", 32'h1c00_0204, 2'd2, 1'b1);
    ar_hs("t4_ar_e");
    req_once("t4_cnt_full", 32'h1c00_0208, 2'd2, 1'b0);
    r_beat(32'h1111_0004, 2'b00, 1'b1);
    r_beat(32'h1111_0005, 2'b00, 1'b1);

    // Unsolicited beat at cnt=0 and a foreign-ID beat are consumed silently.
    a.rvalid = 1'b1;
    a.rdata  = 32'hdead_beef;
    #1 check("unsol_data_ok", {31'd0, s.data_ok}, 32'd0);
    check("unsol_rready", {31'd0, a.rready}, 32'd1);
    tick();
    a.rvalid = 1'b0;
    #1 check("unsol_data_ok_next", {31'd0, s.data_ok}, 32'd0);
    tick();
    req_once("id_accept", 32'h1c00_0300, 2'd2, 1'b1);
    ar_hs("id_ar");
    a.rvalid = 1'b1;
    a.rid    = 4'd3;
    a.rdata  = 32'hbad0_0003;
    #1 check("id_mismatch_data_ok", {31'd0, s.data_ok}, 32'd0);
    tick();
    a.rvalid = 1'b0;
    a.rid    = 4'd0;
    #1 check("id_mismatch_data_ok_next", {31'd0, s.data_ok}, 32'd0);
    tick();
    r_beat(32'h2222_0001, 2'b10, 1'b1);

    // T5: asynchronous reset with an AR pending and cnt=2.
    req_once("t5_accept_h", 32'h1c00_0400, 2'd2, 1'b1);
    ar_hs("t5_ar_h");
    req_once("t5_accept_i", 32'h1c00_0404, 2'd2, 1'b1);
    check("t5_arvalid_pre", {31'd0, a.arvalid}, 32'd1);
    #1 reset = 1'b1;
    #1 check("t5_arvalid_async", {31'd0, a.arvalid}, 32'd0);
    check("t5_araddr_async", a.araddr, 32'd0);
    check("t5_rready_async", {31'd0, a.rready}, 32'd1);
    ar_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    req_once("t5_first_after_rst", 32'h1c00_0500, 2'd2, 1'b1);
    ar_hs("t5_ar_j");
    req_once("t5_second_after_rst", 32'h1c00_0504, 2'd2, 1'b1);
    ar_hs("t5_ar_k");
    r_beat(32'h3333_0001, 2'b00, 1'b1);
    r_beat(32'h3333_0002, 2'b00, 1'b1);

    // T6: write requests are never accepted.
    s.req  = 1'b1;
    s.wr   = 1'b1;
    s.addr = 32'h1c00_0600;
    for (int i = 0; i < 10; i++) begin
      #1 check("t6_addr_ok", {31'd0, s.addr_ok}, 32'd0);
      check("t6_arvalid", {31'd0, a.arvalid}, 32'd0);
      tick();
    end
    s.req = 1'b0;
    s.wr  = 1'b0;

    repeat (3) tick();
    check("ar_queue_drained", ar_q.size(), 32'd0);
    check("data_queue_drained", d_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
